// File: rtl/ram_pkg.sv
// Shared definitions for the single-port bit-masked RAM controller.
package ram_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/ram_strb2mask.sv
// Expands per-byte write strobes into a per-bit RAM write mask.
module ram_strb2mask
    import ram_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    localparam int STRB_WIDTH = DATA_WIDTH / BYTE_W
) (
    input  logic [STRB_WIDTH-1:0] strb,
    output logic [DATA_WIDTH-1:0] mask
);

    for (genvar i = 0; i < STRB_WIDTH; i++) begin : g_byte
        assign mask[i*BYTE_W +: BYTE_W] = {BYTE_W{strb[i]}};
    end

endmodule

// File: rtl/ram_sp_bitmask_ctrl.sv
// Request/response front end for one single-port bit-masked RAM, with a
// zero-fill sequence after every reset.
//
// Handshakes: a request transfers on the rising edge where req_valid &&
// req_ready; a response transfers where rsp_valid && rsp_ready. A valid
// side holds its payload until the transfer; ready may change freely.
module ram_sp_bitmask_ctrl
    import ram_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 16,
    parameter int INIT_EN    = 1,
    localparam int ADDR_WIDTH = $clog2(DEPTH),
    localparam int STRB_WIDTH = DATA_WIDTH / BYTE_W
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic [STRB_WIDTH-1:0] req_wstrb,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  init_done,
    output logic                  ram_cen,
    output logic                  ram_wen,
    output logic [DATA_WIDTH-1:0] ram_bwen,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_din,
    input  logic [DATA_WIDTH-1:0] ram_dout,
    output state_e                dbg_state
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] init_cnt_q, init_cnt_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0] strb_mask;
    logic                  can_accept;
    logic                  accept;

    ram_strb2mask #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_strb2mask (
        .strb(req_wstrb),
        .mask(strb_mask)
    );

    always_comb begin
        state_d     = state_q;
        init_cnt_d  = init_cnt_q;
        rsp_valid_d = rsp_valid_q;
        can_accept  = 1'b0;
        accept      = 1'b0;
        req_ready   = 1'b0;
        init_done   = 1'b0;
        ram_cen     = 1'b0;
        ram_wen     = 1'b0;
        ram_bwen    = '0;
        ram_addr    = '0;
        ram_din     = '0;
        // Outputs are held at their idle values while reset is asserted.
        if (!reset) begin
            case (state_q)
                ST_INIT: begin
                    ram_cen  = 1'b1;
                    ram_wen  = 1'b1;
                    ram_bwen = '1;
                    ram_addr = init_cnt_q;
                    if (init_cnt_q == LAST_ADDR) begin
                        state_d = ST_RUN;
                    end else begin
                        init_cnt_d = init_cnt_q + ADDR_WIDTH'(1);
                    end
                end
                ST_RUN: begin
                    // A stalled response blocks every request so order is kept
                    // and ram_dout stays valid without a holding register.
                    can_accept = !(rsp_valid_q && !rsp_ready);
                    accept     = req_valid && can_accept;
                    req_ready  = can_accept;
                    init_done  = 1'b1;
                    ram_cen    = accept;
                    ram_wen    = req_write;
                    ram_bwen   = strb_mask;
                    ram_addr   = req_addr;
                    ram_din    = req_wdata;
                    if (accept && !req_write) begin
                        rsp_valid_d = 1'b1;
                    end else if (rsp_ready) begin
                        rsp_valid_d = 1'b0;
                    end
                end
                default: begin
                    state_d = ST_RUN;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= (INIT_EN != 0) ? ST_INIT : ST_RUN;
            init_cnt_q  <= '0;
            rsp_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            init_cnt_q  <= init_cnt_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = ram_dout;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_ram_sp_bitmask_ctrl.sv
// Bench for ram_sp_bitmask_ctrl: behavioural RAM, reference memory model and
// response queue, directed scenarios followed by random traffic.
module tb_ram_sp_bitmask_ctrl;
    import ram_pkg::*;

    localparam int DW    = 32;
    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam int SW    = 4;

    // clock / reset
    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    logic          req_valid = 1'b0;
    logic          req_write = 1'b0;
    logic [AW-1:0] req_addr  = '0;
    logic [DW-1:0] req_wdata = '0;
    logic [SW-1:0] req_wstrb = '0;
    logic          rsp_ready = 1'b1;
    logic          req_ready, rsp_valid, init_done;
    logic [DW-1:0] rsp_rdata;
    logic          ram_cen, ram_wen;
    logic [DW-1:0] ram_bwen, ram_din, ram_dout;
    logic [AW-1:0] ram_addr;
    state_e        dbg_state;

    ram_sp_bitmask_ctrl #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .INIT_EN(1)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .init_done(init_done),
        .ram_cen(ram_cen), .ram_wen(ram_wen), .ram_bwen(ram_bwen),
        .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout),
        .dbg_state(dbg_state)
    );

    // second instance without zero-fill, kept idle
    logic          n_req_valid = 1'b0;
    logic          n_rsp_ready = 1'b1;
    logic [DW-1:0] n_ram_dout  = '0;
    logic          n_req_ready, n_rsp_valid, n_init_done, n_ram_cen, n_ram_wen;
    logic [DW-1:0] n_rsp_rdata, n_ram_bwen, n_ram_din;
    logic [AW-1:0] n_ram_addr;
    state_e        n_dbg_state;

    ram_sp_bitmask_ctrl #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .INIT_EN(0)) dut_noinit (
        .clock(clock), .reset(reset),
        .req_valid(n_req_valid), .req_ready(n_req_ready), .req_write(1'b0),
        .req_addr(4'd0), .req_wdata(32'd0), .req_wstrb(4'd0),
        .rsp_valid(n_rsp_valid), .rsp_ready(n_rsp_ready), .rsp_rdata(n_rsp_rdata),
        .init_done(n_init_done),
        .ram_cen(n_ram_cen), .ram_wen(n_ram_wen), .ram_bwen(n_ram_bwen),
        .ram_addr(n_ram_addr), .ram_din(n_ram_din), .ram_dout(n_ram_dout),
        .dbg_state(n_dbg_state)
    );

    // behavioural RAM: bwen bit 1 writes that bit, dout changes only on reads
    logic [DW-1:0] ram_mem [DEPTH];
    always @(posedge clock) begin
        if (ram_cen) begin
            if (ram_wen) ram_mem[ram_addr] <= (ram_mem[ram_addr] & ~ram_bwen) | (ram_din & ram_bwen);
            else         ram_dout <= ram_mem[ram_addr];
        end
    end

    // scoreboard and reference model
    int            checks = 0;
    int            errors = 0;
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] model_mem [DEPTH];
    bit            in_init  = 1'b0;
    int            init_idx = 0;
    bit            prev_rst = 1'b0;
    int            cyc = 0;
    int            init_done_cyc = 0;
    int            init_writes = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0h required %0h at %0t", name, act, exp, $time);
        end
    endtask

    // driver: one cycle of stimulus, then compare against the model and advance it
    task automatic step(input logic rst, input logic v, input logic w, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input logic [SW-1:0] s, input logic rr);
        logic [DW-1:0] merged;
        bit            acc;
        @(negedge clock);
        reset = rst; req_valid = v; req_write = w; req_addr = a;
        req_wdata = d; req_wstrb = s; rsp_ready = rr;
        #1;
        if (rst) begin
            chk("rst_req_ready", req_ready, 0);
            chk("rst_init_done", init_done, 0);
            chk("rst_ram_cen", ram_cen, 0);
            chk("rst_ram_wen", ram_wen, 0);
            chk("rst_ram_bwen", ram_bwen, 0);
            chk("rst_ram_addr", ram_addr, 0);
            chk("rst_ram_din", ram_din, 0);
            chk("rst_noinit_ready", n_req_ready, 0);
            if (prev_rst) chk("rst_rsp_valid", rsp_valid, 0);
            in_init = 1'b1; init_idx = 0; exp_q.delete();
            cyc = 0; init_done_cyc = 0; init_writes = 0;
            prev_rst = 1'b1;
            return;
        end
        prev_rst = 1'b0;
        cyc++;
        if (init_done && init_done_cyc == 0) init_done_cyc = cyc;
        chk("noinit_cen", n_ram_cen, 0);
        if (exp_q.size() != 0) begin
            chk("rsp_valid", rsp_valid, 1);
            chk("rsp_rdata", rsp_rdata, exp_q[0]);
        end else begin
            chk("rsp_valid", rsp_valid, 0);
        end
        if (in_init) begin
            chk("init_req_ready", req_ready, 0);
            chk("init_done_low", init_done, 0);
            chk("init_cen", ram_cen, 1);
            chk("init_wen", ram_wen, 1);
            chk("init_bwen", ram_bwen, 32'hFFFF_FFFF);
            chk("init_addr", ram_addr, init_idx);
            chk("init_din", ram_din, 0);
            if (ram_cen && ram_wen && ram_bwen == 32'hFFFF_FFFF && ram_din == 0 && ram_addr == AW'(init_idx))
                init_writes++;
            model_mem[init_idx] = '0;
            init_idx++;
            if (init_idx == DEPTH) in_init = 1'b0;
            return;
        end
        acc = v && !(exp_q.size() != 0 && !rr);
        chk("req_ready", req_ready, !(exp_q.size() != 0 && !rr));
        chk("init_done", init_done, 1);
        chk("ram_cen", ram_cen, acc);
        if (acc) begin
            chk("ram_wen", ram_wen, w);
            chk("ram_addr", ram_addr, a);
            if (w) begin
                chk("ram_din", ram_din, d);
                for (int b = 0; b < SW; b++)
                    chk("ram_bwen_byte", ram_bwen[b*8 +: 8], s[b] ? 8'hFF : 8'h00);
            end
        end
        if (exp_q.size() != 0 && rr) void'(exp_q.pop_front());
        if (acc && !w) exp_q.push_back(model_mem[a]);
        if (acc && w) begin
            merged = model_mem[a];
            for (int b = 0; b < SW; b++)
                if (s[b]) merged[b*8 +: 8] = d[b*8 +: 8];
            model_mem[a] = merged;
        end
    endtask

    task automatic idle(input logic rr);
        step(0, 0, 0, '0, '0, '0, rr);
    endtask

    initial begin
        // zero-fill after a 2-cycle reset
        step(1, 0, 0, '0, '0, '0, 1);
        step(1, 0, 0, '0, '0, '0, 1);
        idle(1);
        chk("noinit_ready", n_req_ready, 1);
        chk("noinit_done", n_init_done, 1);
        for (int i = 0; i < 16; i++) idle(1);
        chk("init_write_count", init_writes, 16);
        chk("init_done_cycle", init_done_cyc, 17);
        step(0, 1, 0, 4'd9, '0, '0, 1);
        idle(1);
        chk("zero_read_lit", rsp_rdata, 32'h0);

        // byte-masked write
        step(0, 1, 1, 4'd3, 32'hAABBCCDD, 4'hF, 1);
        step(0, 1, 1, 4'd3, 32'h11223344, 4'h5, 1);
        step(0, 1, 0, 4'd3, '0, '0, 1);
        idle(1);
        chk("masked_lit", rsp_rdata, 32'hAA22CC44);

        // back-pressure
        step(0, 1, 0, 4'd3, '0, '0, 1);
        for (int i = 0; i < 4; i++) begin
            step(0, 1, 0, 4'd5, '0, '0, 0);
            chk("stall_ready_lit", req_ready, 0);
            chk("stall_data_lit", rsp_rdata, 32'hAA22CC44);
        end
        step(0, 1, 0, 4'd5, '0, '0, 1);
        chk("release_accept_lit", ram_cen, 1);
        idle(1);

        // streaming
        for (int i = 0; i < 8; i++) step(0, 1, 1, AW'(i), 32'h0101_0101 * i, 4'hF, 1);
        for (int i = 0; i < 8; i++) begin
            step(0, 1, 0, AW'(i), '0, '0, 1);
            if (i > 0) begin
                chk("stream_valid_lit", rsp_valid, 1);
                chk("stream_data_lit", rsp_rdata, 32'h0101_0101 * (i - 1));
            end
        end
        idle(1);
        chk("stream_last_lit", rsp_rdata, 32'h0707_0707);

        // random traffic
        for (int i = 0; i < 400; i++)
            step(0, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                 AW'($urandom_range(0, DEPTH - 1)), $urandom, SW'($urandom_range(0, 15)),
                 $urandom_range(0, 3) != 0);
        idle(1);

        // make addr 3 non-zero, then reset during a stalled response
        step(0, 1, 1, 4'd3, 32'hDEADBEEF, 4'hF, 1);
        step(0, 1, 0, 4'd3, '0, '0, 1);
        idle(0);
        chk("stall_before_rst_lit", rsp_valid, 1);
        step(1, 0, 0, '0, '0, '0, 0);
        step(1, 0, 0, '0, '0, '0, 0);
        idle(1);
        chk("reinit_addr_lit", ram_addr, 0);
        for (int i = 0; i < 16; i++) idle(1);
        chk("reinit_done_cycle", init_done_cyc, 17);
        step(0, 1, 0, 4'd3, '0, '0, 1);
        idle(1);
        chk("cleared_lit", rsp_rdata, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
